// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, skid buffer, redirects.
// Define FETCH_CTRL_EXC_EN to add the ExcReq/ExcVector redirect source.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        Clk,
    input  logic        RstN,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    input  logic        StallIn,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
`ifdef FETCH_CTRL_EXC_EN
    input  logic        ExcReq,
    input  logic [31:0] ExcVector,
`endif
    output logic [31:0] Instruction,
    output logic [31:0] PCAdd4,
    output logic        InstValid,
    output logic        Stall,
    output logic        Flush,
    output logic [31:0] PCOut
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic        req_d;
    logic [31:0] addr_d;
    logic [31:0] pc_d;
    logic [31:0] inst_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        flush_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_addr_q, skid_addr_d;
    logic        redir;
    logic [31:0] tgt;

    // Exception redirect outranks a branch from ID
`ifdef FETCH_CTRL_EXC_EN
    assign redir = ExcReq | BranchTaken;
    assign tgt   = ExcReq ? ExcVector : BranchTarget;
`else
    assign redir = BranchTaken;
    assign tgt   = BranchTarget;
`endif

    assign Stall = StallIn;

    always_comb begin
        state_d     = state_q;
        req_d       = ImemReq;
        addr_d      = ImemAddr;
        pc_d        = PCOut;
        inst_d      = Instruction;
        pc4_d       = PCAdd4;
        valid_d     = InstValid;
        flush_d     = redir;
        skid_data_d = skid_data_q;
        skid_addr_d = skid_addr_q;
        if (redir) begin
            pc_d    = tgt;
            valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = redir ? tgt : PCOut;
            end
            FETCH: begin
                if (redir) begin
                    // An unacked request must complete before retargeting
                    if (ImemAck) addr_d = tgt;
                    else state_d = DRAIN;
                end else if (ImemAck) begin
                    if (StallIn) begin
                        skid_data_d = ImemRdata;
                        skid_addr_d = ImemAddr;
                        req_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        inst_d  = ImemRdata;
                        pc4_d   = ImemAddr + 32'd4;
                        valid_d = 1'b1;
                        pc_d    = ImemAddr + 32'd4;
                        addr_d  = ImemAddr + 32'd4;
                    end
                end else if (!StallIn) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redir) begin
                    addr_d  = tgt;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (!StallIn) begin
                    inst_d  = skid_data_q;
                    pc4_d   = skid_addr_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = skid_addr_q + 32'd4;
                    addr_d  = skid_addr_q + 32'd4;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (ImemAck) begin
                    addr_d  = redir ? tgt : PCOut;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q     <= IDLE;
            ImemReq     <= 1'b0;
            ImemAddr    <= RESET_PC;
            PCOut       <= RESET_PC;
            Instruction <= 32'd0;
            PCAdd4      <= 32'd0;
            InstValid   <= 1'b0;
            Flush       <= 1'b0;
            skid_data_q <= 32'd0;
            skid_addr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            ImemReq     <= req_d;
            ImemAddr    <= addr_d;
            PCOut       <= pc_d;
            Instruction <= inst_d;
            PCAdd4      <= pc4_d;
            InstValid   <= valid_d;
            Flush       <= flush_d;
            skid_data_q <= skid_data_d;
            skid_addr_q <= skid_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a
// transaction-level reference model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ack;
    logic [31:0] rdata;
    logic        stall_in;
    logic        br;
    logic [31:0] br_tgt;
`ifdef FETCH_CTRL_EXC_EN
    logic        exc_req;
    logic [31:0] exc_vec;
`endif
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [31:0] pcout;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .Clk          (clk),
        .RstN         (rst_n),
        .ImemReq      (req),
        .ImemAddr     (addr),
        .ImemAck      (ack),
        .ImemRdata    (rdata),
        .StallIn      (stall_in),
        .BranchTaken  (br),
        .BranchTarget (br_tgt),
`ifdef FETCH_CTRL_EXC_EN
        .ExcReq       (exc_req),
        .ExcVector    (exc_vec),
`endif
        .Instruction  (inst),
        .PCAdd4       (pc4),
        .InstValid    (valid),
        .Stall        (stall),
        .Flush        (flush),
        .PCOut        (pcout)
    );

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    // Reference model: tracks the request in flight, a queue holding at most
    // one stalled word, and whether the in-flight word belongs to a dead path.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } word_t;

    bit          m_started, m_req, m_valid, m_flush, m_drop;
    logic [31:0] m_addr, m_pc, m_inst, m_pc4;
    word_t       held[$];

    task automatic mreset();
        m_started = 0; m_req = 0; m_valid = 0; m_flush = 0; m_drop = 0;
        m_addr = RST_PC; m_pc = RST_PC; m_inst = 0; m_pc4 = 0;
        held.delete();
    endtask

    task automatic deliver(input logic [31:0] a, input logic [31:0] d);
        m_inst = d; m_pc4 = a + 4; m_valid = 1;
        m_pc = a + 4; m_addr = a + 4;
    endtask

    task automatic mstep();
        bit          rd;
        bit          acked;
        logic [31:0] tg;
        word_t       w;
        rd = br;
        tg = br_tgt;
`ifdef FETCH_CTRL_EXC_EN
        if (exc_req) begin rd = 1; tg = exc_vec; end
`endif
        acked = m_req && ack;
        m_flush = rd;
        if (rd) begin m_pc = tg; m_valid = 0; held.delete(); end
        if (!m_started) begin
            m_started = 1; m_req = 1; m_addr = m_pc;
        end else if (rd) begin
            if (!m_req) begin m_req = 1; m_addr = tg; end
            else if (acked) begin m_addr = tg; m_drop = 0; end
            else m_drop = 1;
        end else if (m_drop) begin
            if (acked) begin m_drop = 0; m_addr = m_pc; end
        end else if (held.size() != 0) begin
            if (!stall_in) begin
                w = held.pop_front();
                deliver(w.a, w.d);
                m_req = 1;
            end
        end else if (acked) begin
            if (stall_in) begin
                w.a = m_addr; w.d = rdata;
                held.push_back(w);
                m_req = 0;
            end else deliver(m_addr, rdata);
        end else if (!stall_in) m_valid = 0;
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) mreset();
        else mstep();

    always @(negedge clk)
        if (chk_en) begin
            chk1 ("m.ImemReq", req, m_req);
            chk32("m.ImemAddr", addr, m_addr);
            chk32("m.PCOut", pcout, m_pc);
            chk32("m.Instruction", inst, m_inst);
            chk32("m.PCAdd4", pc4, m_pc4);
            chk1 ("m.InstValid", valid, m_valid);
            chk1 ("m.Flush", flush, m_flush);
            chk1 ("m.Stall", stall, stall_in);
        end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk1 (nm, req, 1'b0);
        chk32(nm, addr, RST_PC);
        chk32(nm, pcout, RST_PC);
        chk32(nm, inst, 32'd0);
        chk32(nm, pc4, 32'd0);
        chk1 (nm, valid, 1'b0);
        chk1 (nm, flush, 1'b0);
    endtask

    initial begin
        ack = 0; rdata = 0; stall_in = 0; br = 0; br_tgt = 0;
`ifdef FETCH_CTRL_EXC_EN
        exc_req = 0; exc_vec = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        chk_en = 1;
        rst_n = 1;
        cyc();
        chk1 ("e1.req", req, 1'b1);
        chk32("e1.addr", addr, RST_PC);
        chk1 ("e1.valid", valid, 1'b0);
        ack = 1; rdata = 32'h1111_0000;
        cyc();
        chk32("e2.addr", addr, 32'hBFC0_0004);
        chk32("e2.pc4", pc4, 32'hBFC0_0004);
        chk32("e2.inst", inst, 32'h1111_0000);
        chk1 ("e2.valid", valid, 1'b1);
        // stall during ack of BFC00004 for three cycles
        stall_in = 1; rdata = 32'h2222_0004;
        cyc();
        chk1 ("hold.req", req, 1'b0);
        chk32("hold.inst", inst, 32'h1111_0000);
        ack = 0; rdata = 32'hDEAD_BEEF;
        cyc();
        chk32("hold.pc4", pc4, 32'hBFC0_0004);
        chk1 ("hold.req2", req, 1'b0);
        cyc();
        stall_in = 0;
        cyc();
        chk32("rel.inst", inst, 32'h2222_0004);
        chk32("rel.pc4", pc4, 32'hBFC0_0008);
        chk32("rel.addr", addr, 32'hBFC0_0008);
        chk1 ("rel.req", req, 1'b1);
        // branch while BFC00008 is still outstanding
        br = 1; br_tgt = 32'h8000_0100;
        cyc();
        chk32("drain.addr", addr, 32'hBFC0_0008);
        chk1 ("drain.flush", flush, 1'b1);
        chk1 ("drain.valid", valid, 1'b0);
        chk32("drain.pcout", pcout, 32'h8000_0100);
        br = 0;
        cyc();
        chk1 ("drain.flush2", flush, 1'b0);
        chk32("drain.addr2", addr, 32'hBFC0_0008);
        ack = 1; rdata = 32'h3333_3333;
        cyc();
        chk32("redir.addr", addr, 32'h8000_0100);
        chk1 ("redir.valid", valid, 1'b0);
        stall_in = 1; rdata = 32'h4444_4444;
        cyc();
        chk1 ("hold2.req", req, 1'b0);
        // branch and stall together in HOLD
        ack = 0; br = 1; br_tgt = 32'h8000_0200;
        cyc();
        chk1 ("hbr.flush", flush, 1'b1);
        chk1 ("hbr.valid", valid, 1'b0);
        chk32("hbr.addr", addr, 32'h8000_0200);
        chk1 ("hbr.req", req, 1'b1);
        br_tgt = 32'hFFFF_FFFC; ack = 1; stall_in = 0;
        cyc();
        chk32("wrap.addr", addr, 32'hFFFF_FFFC);
        br = 0; rdata = 32'h5555_5555;
        cyc();
        chk32("wrap.pc4", pc4, 32'd0);
        chk32("wrap.next", addr, 32'd0);
        chk32("wrap.inst", inst, 32'h5555_5555);
`ifdef FETCH_CTRL_EXC_EN
        exc_req = 1; exc_vec = 32'h8000_0180;
        br = 1; br_tgt = 32'h8000_0100;
        cyc();
        chk32("exc.addr", addr, 32'h8000_0180);
        chk32("exc.pcout", pcout, 32'h8000_0180);
        exc_req = 0; br = 0;
`endif
        // reset in the middle of an outstanding request
        ack = 0;
        cyc();
        chk1("pre_rst.req", req, 1'b1);
        #2 rst_n = 0;
        #1 chk_reset("async_rst");
        ack = 1;
        cyc();
        cyc();
        chk_reset("late_ack");
        rst_n = 1; ack = 0;
        cyc();
        chk1 ("restart.req", req, 1'b1);
        chk32("restart.addr", addr, RST_PC);

        for (int i = 0; i < 3000; i++) begin
            ack = ($urandom_range(0, 99) < 60);
            stall_in = ($urandom_range(0, 99) < 30);
            br = ($urandom_range(0, 99) < 7);
            br_tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom();
            rdata = $urandom();
`ifdef FETCH_CTRL_EXC_EN
            exc_req = ($urandom_range(0, 99) < 3);
            exc_vec = $urandom();
`endif
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 0;
                #4 rst_n = 1;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 RstN  input  1  reset, asynchronous, active-low.
REQ-004 ImemReq  output  1  instruction-memory request, registered.
REQ-005 ImemAddr  output  32  request address, registered, stable while ImemReq high.
REQ-006 ImemAck  input  1  completes the request when sampled high with ImemReq high.
REQ-007 ImemRdata  input  32  instruction word, valid with ImemAck.
REQ-008 StallIn  input  1  hazard-unit hold request for IF/ID.
REQ-009 BranchTaken  input  1  redirect request from ID, one-cycle pulse.
REQ-010 BranchTarget  input  32  redirect address, valid with BranchTaken.
REQ-011 Instruction  output  32  fetched word to IF/ID, registered.
REQ-012 PCAdd4  output  32  fetch address of Instruction plus 4, registered.
REQ-013 InstValid  output  1  Instruction/PCAdd4 hold a real instruction; low means bubble.
REQ-014 Stall  output  1  IF/ID hold; combinational copy of StallIn.
REQ-015 Flush  output  1  IF/ID clear, registered one-cycle pulse.
REQ-016 PCOut  output  32  next-fetch PC register.

Function
REQ-017 States SHALL be IDLE, FETCH, HOLD, DRAIN; exactly one outstanding memory request at any time.
REQ-018 IDLE: ImemReq=0; SHALL go to FETCH one cycle after reset release, driving ImemReq=1, ImemAddr=PCOut.
REQ-019 FETCH, ImemAck=1, no redirect, StallIn=0: Instruction<=ImemRdata, PCAdd4<=ImemAddr+4, InstValid<=1, PCOut/ImemAddr<=ImemAddr+4, ImemReq stays 1; back-to-back acks SHALL yield one instruction per cycle.
REQ-020 FETCH, ImemAck=1, StallIn=1: word and address captured into a one-entry skid buffer, ImemReq<=0, go to HOLD; Instruction/PCAdd4/InstValid unchanged.
REQ-021 FETCH, ImemAck=0: outputs hold if StallIn=1, else InstValid<=0.
REQ-022 HOLD: when StallIn=0, skid moves to Instruction/PCAdd4 with InstValid<=1, PCOut<=skid address+4, ImemReq<=1 with that address, go to FETCH.
REQ-023 Redirect (BranchTaken=1) SHALL override StallIn in every state: PCOut<=target, Flush<=1 next cycle, InstValid<=0, skid discarded.
REQ-024 Redirect in FETCH with ImemAck=1 or in HOLD: ImemAddr<=target, ImemReq<=1, state FETCH; acked word discarded.
REQ-025 Redirect in FETCH with ImemAck=0: ImemReq and ImemAddr SHALL stay unchanged; go to DRAIN.
REQ-026 DRAIN: on ImemAck, returned word discarded, ImemAddr<=PCOut, state FETCH; a further redirect in DRAIN overwrites PCOut and re-pulses Flush.
REQ-027 PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0; bits[1:0] of targets passed unchanged.

Reset
REQ-028 RstN low SHALL immediately force: state IDLE, ImemReq=0, ImemAddr=PCOut=RESET_PC, Instruction=0, PCAdd4=0, InstValid=0, Flush=0, skid empty.
REQ-029 Reset during an outstanding request abandons it; a late ImemAck SHALL be ignored while in IDLE.

Configuration
REQ-030 Macro FETCH_CTRL_EXC_EN defined: ports ExcReq (input 1) and ExcVector (input 32) exist; ExcReq is a redirect with priority over BranchTaken, target ExcVector, otherwise identical to REQ-023..026.
REQ-031 Macro undefined: ExcReq/ExcVector ports absent; BranchTaken is the only redirect source.

Verification
REQ-032 Reset release, ImemAck tied 1 -> ImemAddr BFC00000, BFC00004, BFC00008 on consecutive cycles; InstValid=1 from third cycle, PCAdd4 BFC00004 first.
REQ-033 StallIn=1 during ack of BFC00004 for 3 cycles -> ImemReq=0 in HOLD, outputs frozen; on release Instruction=word@BFC00004, next ImemAddr=BFC00008.
REQ-034 Memory with 3-cycle latency, BranchTaken target 80000100 one cycle after request at BFC00008 -> ImemAddr holds BFC00008 until ack, word discarded, Flush pulse, next ImemAddr=80000100.
REQ-035 BranchTaken and StallIn both high in HOLD -> skid dropped, Flush=1 next cycle, InstValid=0, ImemAddr=target.
REQ-036 With FETCH_CTRL_EXC_EN: ExcReq (ExcVector 80000180) and BranchTaken (80000100) same cycle -> ImemAddr=80000180; RstN low mid-request -> all outputs at reset values same cycle.
